la_eth_gmii_rx: RTL and testbench

GMII receive framer that sits directly downstream of the GMII receive pins of the Ethernet interface.
- Strips preamble/SFD.
- Checks FCS (CRC-32), minimum/maximum length and PHY error.
- Emits the payload without the FCS as a byte stream with first/last/error markers for the MAC-to-UMI packetizer.
- Keeps saturating good/bad frame counters for the status register.

---
 rtl/la_eth_pkg.sv | 38 +++
 rtl/la_eth_crc32.sv | 26 ++
 rtl/la_eth_gmii_rx.sv | 217 +++++++++++++++++++++
 tb/tb_la_eth_gmii_rx.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_eth_pkg.sv
// Shared constants and types for the GMII receive/transmit framers.
// Holds Ethernet framing bytes, CRC-32 constants, FSM states and errcode bits.
package la_eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;

  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;

  localparam int ERR_FCS = 0;
  localparam int ERR_PHY = 1;
  localparam int ERR_LEN = 2;

  typedef enum logic [1:0] {
    ST_DROP = 2'd0,
    ST_IDLE = 2'd1,
    ST_PRE  = 2'd2,
    ST_DATA = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic       err;
  } gmii_in_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic       first;
    logic       last;
    logic       err;
    logic [2:0] errcode;
  } rx_beat_t;

endpackage

// File: rtl/la_eth_crc32.sv
// Byte-wise CRC-32 next-state function, LSB-first (reflected polynomial).
// Purely combinational; shared by the RX and TX framers.
module la_eth_crc32
  import la_eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  // Fold the eight data bits in, least significant bit first.
  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ ETH_CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/la_eth_gmii_rx.sv
// GMII receive framer: strips preamble/SFD, checks FCS/length/RX_ER,
// emits the payload without FCS and keeps saturating good/bad counters.
module la_eth_gmii_rx
  import la_eth_pkg::*;
#(
  parameter int MINLEN = 64,
  parameter int MAXLEN = 1518,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      gmii_rx_data,
  input  logic            gmii_rx_valid,
  input  logic            gmii_rx_error,
  output logic            rx_valid,
  output logic [7:0]      rx_data,
  output logic            rx_first,
  output logic            rx_last,
  output logic            rx_err,
  output logic [2:0]      rx_errcode,
  input  logic            cnt_clr,
  output logic [CNTW-1:0] cnt_good,
  output logic [CNTW-1:0] cnt_bad
);

  localparam int LENW = 16;
  localparam logic [LENW-1:0] MINL = LENW'(MINLEN);
  localparam logic [LENW-1:0] MAXL = LENW'(MAXLEN);

  gmii_in_t        in_d, in_q;
  rx_state_e       state_d, state_q;
  logic [31:0]     crc_d, crc_q, crc_nxt;
  logic [LENW-1:0] len_d, len_q;
  logic [31:0]     dly_d, dly_q;
  logic [2:0]      fill_d, fill_q;
  logic [7:0]      pend_d, pend_q;
  logic            pend_vld_d, pend_vld_q;
  logic            phy_err_d, phy_err_q;
  logic            first_d, first_q;
  rx_beat_t        out_d, out_q;
  logic [CNTW-1:0] cnt_good_d, cnt_good_q;
  logic [CNTW-1:0] cnt_bad_d, cnt_bad_q;
  logic            inc_good, inc_bad;
  logic [2:0]      errc;

  la_eth_crc32 u_crc (
    .crc_in  (crc_q),
    .data    (in_q.data),
    .crc_out (crc_nxt)
  );

  // Capture the GMII pins; free-running so reset release sees the live line.
  always_comb begin
    in_d.valid = gmii_rx_valid;
    in_d.data  = gmii_rx_data;
    in_d.err   = gmii_rx_error;
  end

  // Input register, one stage behind the pins.
  always_ff @(posedge clk) begin
    in_q <= in_d;
  end

  // Framing FSM: next state, datapath updates and the output beat.
  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    len_d      = len_q;
    dly_d      = dly_q;
    fill_d     = fill_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    phy_err_d  = phy_err_q;
    first_d    = first_q;
    out_d      = '0;
    inc_good   = 1'b0;
    inc_bad    = 1'b0;
    errc       = '0;
    unique case (state_q)
      ST_DROP: begin
        if (!in_q.valid) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (in_q.valid) begin
          if (in_q.data == ETH_PREAMBLE) state_d = ST_PRE;
          else                           state_d = ST_DROP;
        end
      end
      ST_PRE: begin
        if (!in_q.valid) begin
          state_d = ST_IDLE;
        end else if (in_q.err) begin
          state_d = ST_DROP;
        end else if (in_q.data == ETH_PREAMBLE) begin
          state_d = ST_PRE;
        end else if (in_q.data == ETH_SFD) begin
          state_d    = ST_DATA;
          crc_d      = ETH_CRC_INIT;
          len_d      = '0;
          fill_d     = '0;
          pend_vld_d = 1'b0;
          phy_err_d  = 1'b0;
          first_d    = 1'b1;
        end else begin
          state_d = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!in_q.valid) begin
          state_d        = ST_IDLE;
          pend_vld_d     = 1'b0;
          errc[ERR_FCS]  = (crc_q != ETH_CRC_RESIDUE);
          errc[ERR_PHY]  = phy_err_q;
          errc[ERR_LEN]  = (len_q < MINL);
          if (pend_vld_q) begin
            out_d.valid   = 1'b1;
            out_d.data    = pend_q;
            out_d.first   = first_q;
            out_d.last    = 1'b1;
            out_d.err     = |errc;
            out_d.errcode = errc;
            inc_good      = ~|errc;
            inc_bad       = |errc;
          end else begin
            inc_bad = 1'b1;
          end
        end else begin
          crc_d     = crc_nxt;
          len_d     = (&len_q) ? len_q : len_q + 1'b1;
          phy_err_d = phy_err_q | in_q.err;
          dly_d     = {dly_q[23:0], in_q.data};
          if (fill_q == 3'd4) begin
            pend_d     = dly_q[31:24];
            pend_vld_d = 1'b1;
          end else begin
            fill_d = fill_q + 3'd1;
          end
          if (pend_vld_q) begin
            out_d.valid = 1'b1;
            out_d.data  = pend_q;
            out_d.first = first_q;
            first_d     = 1'b0;
          end
          // This byte is number MAXLEN+1: close the frame as oversize.
          if (len_q == MAXL) begin
            state_d       = ST_DROP;
            pend_vld_d    = 1'b0;
            errc[ERR_PHY] = phy_err_d;
            errc[ERR_LEN] = 1'b1;
            out_d.last    = 1'b1;
            out_d.err     = 1'b1;
            out_d.errcode = errc;
            inc_bad       = 1'b1;
          end
        end
      end
    endcase
  end

  // Saturating statistics counters; clear wins over increment.
  always_comb begin
    cnt_good_d = cnt_good_q;
    cnt_bad_d  = cnt_bad_q;
    if (cnt_clr) begin
      cnt_good_d = '0;
      cnt_bad_d  = '0;
    end else begin
      if (inc_good && !(&cnt_good_q)) cnt_good_d = cnt_good_q + 1'b1;
      if (inc_bad && !(&cnt_bad_q))   cnt_bad_d  = cnt_bad_q + 1'b1;
    end
  end

  // FSM state register; reset parks in DROP so a partial frame is ignored.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_DROP;
    else       state_q <= state_d;
  end

  // Datapath, output beat and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q      <= ETH_CRC_INIT;
      len_q      <= '0;
      dly_q      <= '0;
      fill_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      phy_err_q  <= 1'b0;
      first_q    <= 1'b0;
      out_q      <= '0;
      cnt_good_q <= '0;
      cnt_bad_q  <= '0;
    end else begin
      crc_q      <= crc_d;
      len_q      <= len_d;
      dly_q      <= dly_d;
      fill_q     <= fill_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      phy_err_q  <= phy_err_d;
      first_q    <= first_d;
      out_q      <= out_d;
      cnt_good_q <= cnt_good_d;
      cnt_bad_q  <= cnt_bad_d;
    end
  end

  assign rx_valid   = out_q.valid;
  assign rx_data    = out_q.data;
  assign rx_first   = out_q.first;
  assign rx_last    = out_q.last;
  assign rx_err     = out_q.err;
  assign rx_errcode = out_q.errcode;
  assign cnt_good   = cnt_good_q;
  assign cnt_bad    = cnt_bad_q;

endmodule

// File: tb/tb_la_eth_gmii_rx.sv
// Directed bench for the GMII receive framer.
// Frames are built with a reference CRC; beats are captured on negedge.
module tb_la_eth_gmii_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  gmii_rx_data = '0;
  logic        gmii_rx_valid = 1'b0;
  logic        gmii_rx_error = 1'b0;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_first;
  logic        rx_last;
  logic        rx_err;
  logic [2:0]  rx_errcode;
  logic        cnt_clr = 1'b0;
  logic [15:0] cnt_good;
  logic [15:0] cnt_bad;

  typedef struct packed {
    logic       f;
    logic       l;
    logic       e;
    logic [2:0] c;
    logic [7:0] d;
  } beat_t;

  beat_t      bq[$];
  int         cq[$];
  logic [7:0] frm[$];
  int         cyc = 0;
  int         t_first = 0;
  int         t_end = 0;
  int         n_run = 0;
  int         n_fail = 0;

  la_eth_gmii_rx u_dut (
    .clk           (clk),
    .reset         (reset),
    .gmii_rx_data  (gmii_rx_data),
    .gmii_rx_valid (gmii_rx_valid),
    .gmii_rx_error (gmii_rx_error),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_first      (rx_first),
    .rx_last       (rx_last),
    .rx_err        (rx_err),
    .rx_errcode    (rx_errcode),
    .cnt_clr       (cnt_clr),
    .cnt_good      (cnt_good),
    .cnt_bad       (cnt_bad)
  );

  always #4 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    beat_t b;
    if (rx_valid) begin
      b.f = rx_first;
      b.l = rx_last;
      b.e = rx_err;
      b.c = rx_errcode;
      b.d = rx_data;
      bq.push_back(b);
      cq.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                          input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if (r[0] ^ d[k]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic build(input int n, input bit fcs);
    logic [31:0] c;
    frm.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n - (fcs ? 4 : 0); i++) begin
      frm.push_back(8'(i * 37 + 11));
      c = crc_upd(c, frm[$]);
    end
    if (fcs) begin
      c = ~c;
      for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic e);
    @(posedge clk);
    #1;
    gmii_rx_valid = v;
    gmii_rx_data  = d;
    gmii_rx_error = e;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic clear_q();
    bq.delete();
    cq.delete();
  endtask

  task automatic clr_cnt();
    @(posedge clk);
    #1 cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
  endtask

  task automatic send(input int er_idx, input int rst_idx, input bit clr_end);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < frm.size(); i++) begin
      drive(1'b1, frm[i], i == er_idx);
      if (i == 0) t_first = cyc;
      if (rst_idx >= 0) begin
        if (i == rst_idx) reset = 1'b1;
        if (i == rst_idx + 1) begin
          @(negedge clk);
          check("rst_valid", 32'(rx_valid), 0);
          check("rst_cnt_good", 32'(cnt_good), 0);
        end
        if (i == rst_idx + 2) begin
          reset = 1'b0;
          clear_q();
        end
      end
    end
    drive(1'b0, 8'h00, 1'b0);
    t_end = cyc;
    if (clr_end) begin
      @(posedge clk);
      #1 cnt_clr = 1'b1;
      @(posedge clk);
      #1 cnt_clr = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag, input int nb,
                             input logic [2:0] code);
    int bad_d, bad_f, bad_l;
    bad_d = 0;
    bad_f = 0;
    bad_l = 0;
    check({tag, "_beats"}, bq.size(), nb);
    foreach (bq[i]) begin
      if (i < frm.size() && bq[i].d !== frm[i]) bad_d++;
      if (bq[i].f !== (i == 0)) bad_f++;
      if (bq[i].l !== (i == bq.size() - 1)) bad_l++;
    end
    check({tag, "_data"}, bad_d, 0);
    check({tag, "_first"}, bad_f, 0);
    check({tag, "_last"}, bad_l, 0);
    if (bq.size() > 0) begin
      check({tag, "_err"}, 32'(bq[$].e), 32'(|code));
      check({tag, "_code"}, 32'(bq[$].c), 32'(code));
    end
  endtask

  initial begin
    idle(4);
    reset = 1'b0;
    idle(1);
    @(negedge clk);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_last", 32'(rx_last), 0);
    check("rst_cnt_good", 32'(cnt_good), 0);
    check("rst_cnt_bad", 32'(cnt_bad), 0);

    // good 64-byte frame
    clear_q();
    build(64, 1);
    send(-1, -1, 1'b0);
    idle(6);
    check_frame("t1", 60, 3'b000);
    check("t1_lat_first", (cq.size() > 0) ? cq[0] - t_first : -1, 7);
    check("t1_lat_last", (cq.size() > 0) ? cq[$] - t_end : -1, 2);
    check("t1_good", 32'(cnt_good), 1);
    check("t1_bad", 32'(cnt_bad), 0);
    clr_cnt();

    // corrupted payload byte 10
    clear_q();
    build(64, 1);
    frm[10] = frm[10] ^ 8'h01;
    send(-1, -1, 1'b0);
    idle(6);
    check_frame("t2", 60, 3'b001);
    check("t2_good", 32'(cnt_good), 0);
    check("t2_bad", 32'(cnt_bad), 1);
    clr_cnt();

    // RX_ER pulse at byte 30
    clear_q();
    build(64, 1);
    send(30, -1, 1'b0);
    idle(6);
    check_frame("t3", 60, 3'b010);
    check("t3_bad", 32'(cnt_bad), 1);
    clr_cnt();

    // runt frame, then a 3-byte fragment
    clear_q();
    build(20, 1);
    send(-1, -1, 1'b0);
    idle(6);
    check_frame("t4a", 16, 3'b100);
    clear_q();
    build(3, 0);
    send(-1, -1, 1'b0);
    idle(6);
    check("t4b_beats", bq.size(), 0);
    check("t4_bad", 32'(cnt_bad), 2);
    check("t4_good", 32'(cnt_good), 0);
    clr_cnt();

    // oversize frame, gap, good frame
    clear_q();
    build(1600, 1);
    send(-1, -1, 1'b0);
    idle(12);
    check_frame("t5a", 1514, 3'b100);
    clear_q();
    build(64, 1);
    send(-1, -1, 1'b0);
    idle(6);
    check_frame("t5b", 60, 3'b000);
    check("t5_bad", 32'(cnt_bad), 1);
    check("t5_good", 32'(cnt_good), 1);

    // reset mid-frame, recovery, clear vs increment
    clear_q();
    send(-1, 20, 1'b0);
    idle(6);
    check("t6a_beats", bq.size(), 0);
    check("t6a_good", 32'(cnt_good), 0);
    check("t6a_bad", 32'(cnt_bad), 0);
    clear_q();
    send(-1, -1, 1'b0);
    idle(6);
    check_frame("t6b", 60, 3'b000);
    check("t6b_good", 32'(cnt_good), 1);
    clear_q();
    send(-1, -1, 1'b1);
    idle(6);
    check("t6c_beats", bq.size(), 60);
    check("t6c_good", 32'(cnt_good), 0);
    check("t6c_bad", 32'(cnt_bad), 0);

    // back-to-back frames with a single idle cycle between
    clear_q();
    send(-1, -1, 1'b0);
    send(-1, -1, 1'b0);
    idle(6);
    check("t7_beats", bq.size(), 120);
    check("t7_good", 32'(cnt_good), 2);
    check("t7_bad", 32'(cnt_bad), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
